// File: rtl/pio_avalon_gpio.sv
// Avalon-MM GPIO slave: data/direction/mask registers, atomic set/clear,
// two-flop input synchroniser, per-bit edge capture and a maskable interrupt.
module pio_avalon_gpio #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_TYPE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] DATA_INIT = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_INIT  = DIR_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] capture_reg, capture_next;
  logic [WIDTH-1:0] s1_reg, s2_reg, s3_reg;
  logic [1:0]       warm_reg;
  logic [WIDTH-1:0] edge_hit;
  logic             warm_done;
  logic             wr_en;

  assign wr_en     = chipselect & ~write_n;
  assign warm_done = (warm_reg == 2'd3);

  // s2/s3 start at zero after reset, so detection waits until both hold real samples.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_hit[gi] = s2_reg[gi] & ~s3_reg[gi] & ~dir_reg[gi] & warm_done;
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_hit[gi] = ~s2_reg[gi] & s3_reg[gi] & ~dir_reg[gi] & warm_done;
      end else begin : g_any
        assign edge_hit[gi] = (s2_reg[gi] ^ s3_reg[gi]) & ~dir_reg[gi] & warm_done;
      end
    end
  endgenerate

  always_comb begin
    data_next    = data_reg;
    dir_next     = dir_reg;
    mask_next    = mask_reg;
    capture_next = capture_reg | edge_hit;
    if (wr_en) begin
      case (address)
        3'd0: data_next = writedata;
        3'd1: dir_next  = writedata;
        3'd2: mask_next = writedata;
        // A new edge in the same cycle as its clear keeps the bit set.
        3'd3: capture_next = (capture_reg & ~writedata) | edge_hit;
        3'd4: data_next = data_reg | writedata;
        3'd5: data_next = data_reg & ~writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= DATA_INIT;
      dir_reg     <= DIR_INIT;
      mask_reg    <= '0;
      capture_reg <= '0;
      s1_reg      <= '0;
      s2_reg      <= '0;
      s3_reg      <= '0;
      warm_reg    <= 2'd0;
    end else begin
      data_reg    <= data_next;
      dir_reg     <= dir_next;
      mask_reg    <= mask_next;
      capture_reg <= capture_next;
      s1_reg      <= pio_in;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      if (!warm_done) begin
        warm_reg <= warm_reg + 2'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = (s2_reg & ~dir_reg) | (data_reg & dir_reg);
      3'd1:    readdata = dir_reg;
      3'd2:    readdata = mask_reg;
      3'd3:    readdata = capture_reg;
      default: readdata = '0;
    endcase
  end

  assign pio_out = data_reg;
  assign pio_oe  = dir_reg;

  generate
    if (IRQ_TYPE == 0) begin : g_irq_level
      assign irq = |(s2_reg & ~dir_reg & mask_reg);
    end else begin : g_irq_edge
      assign irq = |(capture_reg & mask_reg);
    end
  endgenerate

endmodule

// File: tb/tb_pio_avalon_gpio.sv
// Directed bench for pio_avalon_gpio: an edge-IRQ instance and a level-IRQ
// instance share the bus; expectations are queued, then popped at each sample.
module tb_pio_avalon_gpio;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] address;
  logic       cs, cs_lvl;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] pio_in;
  logic [7:0] rd_main, rd_lvl;
  logic [7:0] out_main, out_lvl;
  logic [7:0] oe_main, oe_lvl;
  logic       irq_main, irq_lvl;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pio_avalon_gpio #(
    .WIDTH(8), .RESET_VALUE(32'hA5), .DIR_RESET(32'hFF), .EDGE_TYPE(0), .IRQ_TYPE(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(writedata), .readdata(rd_main), .pio_in(pio_in),
    .pio_out(out_main), .pio_oe(oe_main), .irq(irq_main)
  );

  pio_avalon_gpio #(
    .WIDTH(8), .RESET_VALUE(32'h00), .DIR_RESET(32'h00), .EDGE_TYPE(0), .IRQ_TYPE(0)
  ) dut_lvl (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_lvl), .write_n(write_n),
    .writedata(writedata), .readdata(rd_lvl), .pio_in(pio_in),
    .pio_out(out_lvl), .pio_oe(oe_lvl), .irq(irq_lvl)
  );

  task automatic expect_val(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=0x%0h expected=<none>", observed);
    end else begin
      expected = exp_q.pop_front();
      tag      = tag_q.pop_front();
      assert (observed === expected)
        $display("[%0t] check %s observed=0x%0h expected=0x%0h ok", $time, tag, observed, expected);
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
    end
  endtask

  // Called at a falling edge; the strobe is seen by the next rising edge.
  task automatic wr(input logic lvl, input logic [2:0] a, input logic [7:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (lvl) cs_lvl = 1'b1;
    else     cs     = 1'b1;
    @(negedge clk);
    cs      = 1'b0;
    cs_lvl  = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic lvl, input logic [2:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = lvl ? rd_lvl : rd_main;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    reset = 1'b1; address = 3'd0; cs = 1'b0; cs_lvl = 1'b0; write_n = 1'b1;
    writedata = 8'h00; pio_in = 8'hFF;
    idle(3);
    reset = 1'b0;

    expect_val("reset_pio_out", 32'hA5);   check(out_main);
    expect_val("reset_pio_oe", 32'hFF);    check(oe_main);
    expect_val("reset_irq", 32'h0);        check(irq_main);
    expect_val("reset_irq_lvl", 32'h0);    check(irq_lvl);
    idle(10);
    expect_val("warmup_cap_main", 32'h0);  rd(0, 3'd3, d); check(d);
    expect_val("warmup_cap_lvl", 32'h0);   rd(1, 3'd3, d); check(d);

    expect_val("data_write", 32'h0F);      wr(0, 3'd0, 8'h0F); check(out_main);
    expect_val("outset", 32'h3F);          wr(0, 3'd4, 8'h30); check(out_main);
    expect_val("outclear", 32'h3C);        wr(0, 3'd5, 8'h03); check(out_main);
    expect_val("read_addr4", 32'h0);       rd(0, 3'd4, d); check(d);
    expect_val("read_addr5", 32'h0);       rd(0, 3'd5, d); check(d);
    expect_val("read_addr6", 32'h0);       rd(0, 3'd6, d); check(d);
    expect_val("read_data_out", 32'h3C);   rd(0, 3'd0, d); check(d);

    pio_in = 8'h00;
    idle(3);
    wr(0, 3'd1, 8'h00);
    wr(0, 3'd2, 8'h01);
    expect_val("cap_before_edge", 32'h0);  rd(0, 3'd3, d); check(d);
    pio_in = 8'h01;
    idle(2);
    expect_val("irq_edge_k1", 32'h0);      check(irq_main);
    idle(1);
    expect_val("irq_edge_k2", 32'h1);      check(irq_main);
    expect_val("cap_after_edge", 32'h01);  rd(0, 3'd3, d); check(d);
    expect_val("pin_readback", 32'h01);    rd(0, 3'd0, d); check(d);
    expect_val("irq_after_clear", 32'h0);  wr(0, 3'd3, 8'h01); check(irq_main);
    expect_val("cap_after_clear", 32'h0);  rd(0, 3'd3, d); check(d);

    pio_in = 8'h00;
    idle(3);
    pio_in = 8'h01;
    idle(3);
    expect_val("cap_rearmed", 32'h01);     rd(0, 3'd3, d); check(d);
    pio_in = 8'h00;
    idle(3);
    pio_in = 8'h01;
    idle(2);
    wr(0, 3'd3, 8'h01);
    expect_val("set_wins_cap", 32'h01);    rd(0, 3'd3, d); check(d);
    expect_val("set_wins_irq", 32'h1);     check(irq_main);

    wr(1, 3'd2, 8'h80);
    pio_in = 8'h80;
    idle(1);
    expect_val("lvl_irq_1edge", 32'h0);    check(irq_lvl);
    idle(1);
    expect_val("lvl_irq_2edge", 32'h1);    check(irq_lvl);
    expect_val("lvl_pin_readback", 32'h80); rd(1, 3'd0, d); check(d);
    expect_val("lvl_irq_dir_out", 32'h0);  wr(1, 3'd1, 8'h80); check(irq_lvl);
    expect_val("lvl_readback_dout", 32'h00); rd(1, 3'd0, d); check(d);
    wr(1, 3'd4, 8'h80);
    expect_val("lvl_readback_set", 32'h80); rd(1, 3'd0, d); check(d);
    expect_val("lvl_pio_out", 32'h80);     check(out_lvl);

    expect_val("pre_reset_irq", 32'h1);    check(irq_main);
    reset = 1'b1;
    wr(0, 3'd0, 8'hFF);
    reset = 1'b0;
    expect_val("rst_wr_pio_out", 32'hA5);  check(out_main);
    expect_val("rst_wr_pio_oe", 32'hFF);   check(oe_main);
    expect_val("rst_wr_irq", 32'h0);       check(irq_main);
    expect_val("rst_wr_mask", 32'h0);      rd(0, 3'd2, d); check(d);
    expect_val("rst_wr_cap", 32'h0);       rd(0, 3'd3, d); check(d);
    expect_val("rst_wr_dir", 32'hFF);      rd(0, 3'd1, d); check(d);
    expect_val("rst_wr_data", 32'hA5);     rd(0, 3'd0, d); check(d);
    expect_val("rst_lvl_oe", 32'h00);      check(oe_lvl);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
